multiport_block_memory: RTL and testbench
=========================================

Name: multiport_block_memory

Overview:
Parametrised successor to the three-port data memory. Word-addressed RAM with one block-write port and READ_PORTS independent registered read ports; each read port returns a single word and the surrounding block. Adds per-word write mask, address wrap-around, write-first forwarding, and a self-clearing init sequencer after reset. Sits between the execute/memory stage and the load/store path of the cpu.

Parameters:
WORD_SIZE, 32, bits per word
BLOCK_SIZE, 4, words per block; power of two, <= DEPTH
DEPTH, 64, words of storage; power of two
READ_PORTS, 3, number of independent read ports
PTR_WIDTH, 32, pointer width; only low log2(DEPTH) bits are used

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
init_busy  out  1  high while the clear sequencer runs
wr_en  in  1  block write request
wr_ptr  in  PTR_WIDTH  word address of block word 0
wr_block  in  WORD_SIZE*BLOCK_SIZE  write data; word i at bits [i*WORD_SIZE +: WORD_SIZE]
wr_mask  in  BLOCK_SIZE  per-word write enable
rd_en  in  READ_PORTS  per-port read request
rd_ptr  in  PTR_WIDTH*READ_PORTS  port p pointer at [p*PTR_WIDTH +: PTR_WIDTH]
rd_data  out  WORD_SIZE*READ_PORTS  word at pointer, port p at [p*WORD_SIZE +: WORD_SIZE]
rd_block  out  WORD_SIZE*BLOCK_SIZE*READ_PORTS  block starting at pointer, same packing
rd_valid  out  READ_PORTS  port p output updated this cycle

Behaviour:
- Address of block word i = (ptr + i) mod DEPTH; unaligned pointers allowed, wraps past DEPTH-1 to 0.
- Reset (rst high at edge): rd_data, rd_block, rd_valid <= 0; state <= CLEAR; clear_ptr <= 0; init_busy = 1 from following cycle. rst during CLEAR restarts from 0; rst in RUN discards nothing but re-clears all memory.
- State CLEAR: each cycle writes zero to BLOCK_SIZE words at clear_ptr, clear_ptr += BLOCK_SIZE. After DEPTH/BLOCK_SIZE cycles -> RUN; init_busy drops same edge. wr_en and rd_en ignored in CLEAR; rd_valid stays 0.
- State RUN: write at edge when wr_en=1: for each i with wr_mask[i]=1, mem[(wr_ptr+i) mod DEPTH] <= word i. wr_mask=0 -> no change.
- Read: latency 1. rd_en[p]=1 at edge N -> after edge N, rd_data[p]=mem[ptr], rd_block[p] word i = mem[(ptr+i) mod DEPTH], rd_valid[p]=1. rd_en[p]=0 -> rd_valid[p]=0, rd_data/rd_block hold previous values.
- Read-during-write: write-first per word; any read word whose address is written (mask bit set) in same cycle returns the new value. Unmasked words return old contents.
- All ports may read identical or overlapping addresses simultaneously; no arbitration, no stall.
- Ptr bits above log2(DEPTH) ignored.

Test Plan:
1. DEPTH=16, BLOCK_SIZE=4: rst high 1 cycle -> init_busy=1 for exactly 4 cycles, then 0; reads of ptr 0,7,15 return 0 with rd_valid=1 one cycle after rd_en.
2. Write ptr=3, block {w0=A0,w1=A1,w2=A2,w3=A3}, mask 1111 -> next cycle read ports ptr 3,4,6 give rd_data A0,A1,A3; port0 rd_block = {A0,A1,A2,A3}.
3. Wrap: write ptr=14 block {B0..B3} -> mem[14]=B0, mem[15]=B1, mem[0]=B2, mem[1]=B3; read ptr=14 rd_block={B0,B1,B2,B3}; ptr=0x30 reads as 0.
4. Mask: over test 2 data write ptr=3 block {C0..C3} mask 0101 -> reads 3..6 = C0,A1,C2,A3.
5. Same-cycle write ptr=8 {D0..D3} mask 1111 and read ptr=9 -> rd_data=D1, rd_block={D1,D2,D3,old mem[12]}.
6. wr_en=1 and rd_en=111 during CLEAR -> no memory change, rd_valid=000; rst asserted at clear cycle 2 -> init_busy stays high a further 4 cycles.

Source files
------------

// File: rtl/multiport_block_memory.sv
// ---------------------------------------------------------------------------
// multiport_block_memory
//
// Word-addressed RAM with one block-write port and READ_PORTS registered read
// ports. Each read port returns the word at its pointer plus the BLOCK_SIZE
// word block starting there. Block addresses wrap modulo DEPTH, so unaligned
// pointers are legal. Writes carry a per-word mask. Reads are write-first per
// word. After reset a sequencer zeroes the whole array before normal
// operation resumes.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset; restarts the clear sequence
//   init_busy  high while the clear sequencer runs
//   wr_en      block write request
//   wr_ptr     word address of block word 0 (only low log2(DEPTH) bits used)
//   wr_block   write data, word i at [i*WORD_SIZE +: WORD_SIZE]
//   wr_mask    per-word write enable
//   rd_en      per-port read request
//   rd_ptr     port p pointer at [p*PTR_WIDTH +: PTR_WIDTH]
//   rd_data    port p word at [p*WORD_SIZE +: WORD_SIZE]
//   rd_block   port p block at [p*WORD_SIZE*BLOCK_SIZE +: WORD_SIZE*BLOCK_SIZE]
//   rd_valid   port p outputs were updated by the last edge
// ---------------------------------------------------------------------------
module multiport_block_memory #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int DEPTH      = 64,
  parameter int READ_PORTS = 3,
  parameter int PTR_WIDTH  = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  output logic                                       init_busy,
  input  logic                                       wr_en,
  input  logic [PTR_WIDTH-1:0]                       wr_ptr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]            wr_block,
  input  logic [BLOCK_SIZE-1:0]                      wr_mask,
  input  logic [READ_PORTS-1:0]                      rd_en,
  input  logic [PTR_WIDTH*READ_PORTS-1:0]            rd_ptr,
  output logic [WORD_SIZE*READ_PORTS-1:0]            rd_data,
  output logic [WORD_SIZE*BLOCK_SIZE*READ_PORTS-1:0] rd_block,
  output logic [READ_PORTS-1:0]                      rd_valid
);

  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BLOCK_BITS = WORD_SIZE * BLOCK_SIZE;
  localparam logic [ADDR_WIDTH-1:0] CLEAR_STEP = ADDR_WIDTH'(BLOCK_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_CLEAR_PTR = ADDR_WIDTH'(DEPTH - BLOCK_SIZE);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clear_ptr_reg, clear_ptr_next;

  logic                    running;
  logic                    clearing;

  // Per-word write lanes, shared by the clear sequencer and the write port.
  logic [ADDR_WIDTH-1:0]   wr_addr    [BLOCK_SIZE];
  logic [WORD_SIZE-1:0]    wr_word    [BLOCK_SIZE];
  logic                    wr_word_en [BLOCK_SIZE];

  logic [WORD_SIZE-1:0]    mem [DEPTH];

  logic [BLOCK_BITS*READ_PORTS-1:0] rd_block_next;
  logic [WORD_SIZE*READ_PORTS-1:0]  rd_data_reg;
  logic [BLOCK_BITS*READ_PORTS-1:0] rd_block_reg;
  logic [READ_PORTS-1:0]            rd_valid_reg;

  // Pointer bits above the address range are deliberately ignored.
  logic unused_ptr_bits;
  assign unused_ptr_bits = ^{wr_ptr, rd_ptr};

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      clear_ptr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_ptr_reg <= clear_ptr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clear_ptr_next = clear_ptr_reg;
    if (state_reg == CLEAR) begin
      clear_ptr_next = clear_ptr_reg + CLEAR_STEP;
      if (clear_ptr_reg == LAST_CLEAR_PTR) begin
        state_next = RUN;
      end
    end
  end

  assign init_busy = (state_reg == CLEAR);
  assign running   = (state_reg == RUN) && !rst;
  assign clearing  = (state_reg == CLEAR) && !rst;

  // ------------------------------------------------------------ write lanes
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      wr_addr[i]    = wr_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
      wr_word[i]    = wr_block[i*WORD_SIZE +: WORD_SIZE];
      wr_word_en[i] = running && wr_en && wr_mask[i];
      if (clearing) begin
        wr_addr[i]    = clear_ptr_reg + ADDR_WIDTH'(i);
        wr_word[i]    = '0;
        wr_word_en[i] = 1'b1;
      end
    end
  end

  // Lane addresses within one block are distinct because BLOCK_SIZE <= DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (wr_word_en[i]) begin
        mem[wr_addr[i]] <= wr_word[i];
      end
    end
  end

  // -------------------------------------------------------------- read path
  // Each read word is looked up in the array and then overridden by any
  // write lane hitting the same address this cycle (write-first).
  for (genvar gp = 0; gp < READ_PORTS; gp++) begin : g_port
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_word
      logic [ADDR_WIDTH-1:0] addr;
      logic [WORD_SIZE-1:0]  word;

      assign addr = rd_ptr[gp*PTR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(gi);

      always_comb begin
        word = mem[addr];
        for (int j = 0; j < BLOCK_SIZE; j++) begin
          if (wr_word_en[j] && (wr_addr[j] == addr)) begin
            word = wr_word[j];
          end
        end
      end

      assign rd_block_next[(gp*BLOCK_SIZE + gi)*WORD_SIZE +: WORD_SIZE] = word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_block_reg <= '0;
      rd_valid_reg <= '0;
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        rd_valid_reg[p] <= running && rd_en[p];
        if (running && rd_en[p]) begin
          rd_block_reg[p*BLOCK_BITS +: BLOCK_BITS] <= rd_block_next[p*BLOCK_BITS +: BLOCK_BITS];
          rd_data_reg[p*WORD_SIZE +: WORD_SIZE]    <= rd_block_next[p*BLOCK_BITS +: WORD_SIZE];
        end
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_block = rd_block_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_multiport_block_memory.sv
// ---------------------------------------------------------------------------
// Testbench for multiport_block_memory (DEPTH=16, BLOCK_SIZE=4, 3 read ports).
// A behavioural model (plain array, write applied before reads) tracks the
// expected outputs; scenario tasks check directed values and the model.
// ---------------------------------------------------------------------------
module tb_multiport_block_memory;
  localparam int W  = 32;
  localparam int BS = 4;
  localparam int D  = 16;
  localparam int RP = 3;
  localparam int PW = 32;

  logic              clk;
  logic              rst;
  logic              init_busy;
  logic              wr_en;
  logic [PW-1:0]     wr_ptr;
  logic [W*BS-1:0]   wr_block;
  logic [BS-1:0]     wr_mask;
  logic [RP-1:0]     rd_en;
  logic [PW*RP-1:0]  rd_ptr;
  logic [W*RP-1:0]   rd_data;
  logic [W*BS*RP-1:0] rd_block;
  logic [RP-1:0]     rd_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] model_mem [D];
  logic [W-1:0] exp_data  [RP];
  logic [W-1:0] exp_block [RP][BS];
  logic [RP-1:0] exp_valid;
  int clear_left = 0;
  int clear_base = 0;

  multiport_block_memory #(
    .WORD_SIZE (W),
    .BLOCK_SIZE(BS),
    .DEPTH     (D),
    .READ_PORTS(RP),
    .PTR_WIDTH (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .wr_en    (wr_en),
    .wr_ptr   (wr_ptr),
    .wr_block (wr_block),
    .wr_mask  (wr_mask),
    .rd_en    (rd_en),
    .rd_ptr   (rd_ptr),
    .rd_data  (rd_data),
    .rd_block (rd_block),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] mk(logic [7:0] tag, int i);
    return {tag, 16'h5A5A, 8'(i)};
  endfunction

  function automatic logic [W-1:0] dut_word(int p, int i);
    return rd_block[(p*BS + i)*W +: W];
  endfunction

  function automatic logic [W-1:0] dut_data(int p);
    return rd_data[p*W +: W];
  endfunction

  task automatic set_block(logic [7:0] tag);
    for (int i = 0; i < BS; i++) wr_block[i*W +: W] = mk(tag, i);
  endtask

  task automatic set_rptr(int p, logic [PW-1:0] ptr);
    rd_ptr[p*PW +: PW] = ptr;
  endtask

  // One clock edge; the model applies the spec rules to the inputs present
  // at the edge, then outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      exp_valid = '0;
      for (int p = 0; p < RP; p++) begin
        exp_data[p] = '0;
        for (int i = 0; i < BS; i++) exp_block[p][i] = '0;
      end
      clear_left = D / BS;
      clear_base = 0;
    end else if (clear_left > 0) begin
      for (int i = 0; i < BS; i++) model_mem[(clear_base + i) % D] = '0;
      clear_base += BS;
      clear_left--;
      exp_valid = '0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < BS; i++)
          if (wr_mask[i]) model_mem[int'(wr_ptr % 32'(D) + 32'(i)) % D] = wr_block[i*W +: W];
      end
      for (int p = 0; p < RP; p++) begin
        exp_valid[p] = rd_en[p];
        if (rd_en[p]) begin
          int base;
          base = int'(rd_ptr[p*PW +: PW] % 32'(D));
          exp_data[p] = model_mem[base];
          for (int i = 0; i < BS; i++) exp_block[p][i] = model_mem[(base + i) % D];
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = '0; wr_mask = '0; wr_ptr = '0;
    wr_block = '0; rd_ptr = '0;
    cycle();
    rst = 1'b0;
    checks++;
    if (rd_valid !== 3'b000 || rd_data !== '0 || rd_block !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h expected valid=000 data=0", rd_valid, rd_data);
    end
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (init_busy !== (k < 4)) begin
        errors++;
        $display("FAIL reset_init_busy[%0d]: got %b expected %b", k, init_busy, (k < 4));
      end
      if (k < 4) cycle();
    end
    rd_en = 3'b111;
    set_rptr(0, 0); set_rptr(1, 7); set_rptr(2, 15);
    cycle();
    rd_en = '0;
    checks++;
    if (rd_valid !== 3'b111) begin
      errors++;
      $display("FAIL reset_read_valid: got %b expected 111", rd_valid);
    end
    for (int p = 0; p < RP; p++) begin
      checks++;
      if (dut_data(p) !== 32'h0) begin
        errors++;
        $display("FAIL reset_read_data[%0d]: got %h expected 0", p, dut_data(p));
      end
    end
    $display("test_reset: busy window and zero reads done");
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_ptr = 3; wr_mask = 4'b1111; set_block(8'hA0);
    cycle();
    wr_en = 1'b0;
    rd_en = 3'b111;
    set_rptr(0, 3); set_rptr(1, 4); set_rptr(2, 6);
    cycle();
    rd_en = '0;
    checks++;
    if (dut_data(0) !== mk(8'hA0, 0) || dut_data(1) !== mk(8'hA0, 1) || dut_data(2) !== mk(8'hA0, 3)) begin
      errors++;
      $display("FAIL write_read_data: got %h %h %h expected %h %h %h", dut_data(0), dut_data(1),
               dut_data(2), mk(8'hA0, 0), mk(8'hA0, 1), mk(8'hA0, 3));
    end
    for (int i = 0; i < BS; i++) begin
      checks++;
      if (dut_word(0, i) !== mk(8'hA0, i)) begin
        errors++;
        $display("FAIL write_read_block[%0d]: got %h expected %h", i, dut_word(0, i), mk(8'hA0, i));
      end
    end
    $display("test_write_read: ptr 3 block readback done");
  endtask

  task automatic test_wrap();
    wr_en = 1'b1; wr_ptr = 14; wr_mask = 4'b1111; set_block(8'hB0);
    cycle();
    wr_en = 1'b0;
    rd_en = 3'b111;
    set_rptr(0, 14); set_rptr(1, 32'h30); set_rptr(2, 32'hFFFF_FFF1);
    cycle();
    rd_en = '0;
    for (int i = 0; i < BS; i++) begin
      checks++;
      if (dut_word(0, i) !== mk(8'hB0, i)) begin
        errors++;
        $display("FAIL wrap_block[%0d]: got %h expected %h", i, dut_word(0, i), mk(8'hB0, i));
      end
    end
    checks++;
    if (dut_data(1) !== mk(8'hB0, 2)) begin
      errors++;
      $display("FAIL wrap_ptr_0x30: got %h expected %h", dut_data(1), mk(8'hB0, 2));
    end
    checks++;
    if (dut_data(2) !== mk(8'hB0, 3)) begin
      errors++;
      $display("FAIL wrap_high_bits: got %h expected %h", dut_data(2), mk(8'hB0, 3));
    end
    $display("test_wrap: wrap-around write and high pointer bits done");
  endtask

  task automatic test_mask();
    logic [W-1:0] want [BS];
    wr_en = 1'b1; wr_ptr = 3; wr_mask = 4'b0101; set_block(8'hC0);
    cycle();
    wr_en = 1'b0;
    rd_en = 3'b001; set_rptr(0, 3);
    cycle();
    rd_en = '0;
    want[0] = mk(8'hC0, 0); want[1] = mk(8'hA0, 1);
    want[2] = mk(8'hC0, 2); want[3] = mk(8'hA0, 3);
    for (int i = 0; i < BS; i++) begin
      checks++;
      if (dut_word(0, i) !== want[i]) begin
        errors++;
        $display("FAIL mask_block[%0d]: got %h expected %h", i, dut_word(0, i), want[i]);
      end
    end
    checks++;
    if (rd_valid !== 3'b001) begin
      errors++;
      $display("FAIL mask_valid: got %b expected 001", rd_valid);
    end
    $display("test_mask: masked write over earlier data done");
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] old12;
    logic [W-1:0] old7;
    logic [W-1:0] want0 [BS];
    logic [W-1:0] want1 [BS];
    old12 = model_mem[12];
    old7  = model_mem[7];
    wr_en = 1'b1; wr_ptr = 8; wr_mask = 4'b1111; set_block(8'hD0);
    rd_en = 3'b011; set_rptr(0, 9); set_rptr(1, 7); set_rptr(2, 8);
    cycle();
    wr_en = 1'b0; rd_en = '0;
    want0[0] = mk(8'hD0, 1); want0[1] = mk(8'hD0, 2); want0[2] = mk(8'hD0, 3); want0[3] = old12;
    want1[0] = old7; want1[1] = mk(8'hD0, 0); want1[2] = mk(8'hD0, 1); want1[3] = mk(8'hD0, 2);
    checks++;
    if (dut_data(0) !== mk(8'hD0, 1)) begin
      errors++;
      $display("FAIL same_cycle_data: got %h expected %h", dut_data(0), mk(8'hD0, 1));
    end
    for (int i = 0; i < BS; i++) begin
      checks++;
      if (dut_word(0, i) !== want0[i] || dut_word(1, i) !== want1[i]) begin
        errors++;
        $display("FAIL same_cycle_block[%0d]: got %h/%h expected %h/%h", i, dut_word(0, i),
                 dut_word(1, i), want0[i], want1[i]);
      end
    end
    checks++;
    if (rd_valid !== 3'b011) begin
      errors++;
      $display("FAIL same_cycle_valid: got %b expected 011", rd_valid);
    end
    // Port 2 was idle: it must still hold the word read in test_wrap.
    checks++;
    if (dut_data(2) !== mk(8'hB0, 3)) begin
      errors++;
      $display("FAIL idle_port_hold: got %h expected %h", dut_data(2), mk(8'hB0, 3));
    end
    $display("test_same_cycle: write-first forwarding and hold done");
  endtask

  task automatic test_clear_ignored();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wr_en = 1'b1; wr_ptr = 0; wr_mask = 4'b1111; set_block(8'hE0);
    rd_en = 3'b111; set_rptr(0, 0); set_rptr(1, 4); set_rptr(2, 8);
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (rd_valid !== 3'b000 || init_busy !== 1'b1) begin
        errors++;
        $display("FAIL clear_ignore[%0d]: got valid=%b busy=%b expected valid=000 busy=1", k, rd_valid, init_busy);
      end
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (init_busy !== (k < 4) || rd_valid !== 3'b000) begin
        errors++;
        $display("FAIL clear_restart[%0d]: got busy=%b valid=%b expected busy=%b valid=000",
                 k, init_busy, rd_valid, (k < 4));
      end
      if (k < 4) cycle();
    end
    wr_en = 1'b0;
    rd_en = 3'b111; set_rptr(0, 0); set_rptr(1, 4); set_rptr(2, 8);
    cycle();
    checks++;
    if (rd_block !== '0 || rd_valid !== 3'b111) begin
      errors++;
      $display("FAIL clear_contents_a: got valid=%b block=%h expected valid=111 block=0", rd_valid, rd_block);
    end
    set_rptr(0, 12);
    cycle();
    rd_en = '0;
    checks++;
    if (dut_word(0, 0) !== 32'h0 || dut_word(0, 1) !== 32'h0 || dut_word(0, 2) !== 32'h0 || dut_word(0, 3) !== 32'h0) begin
      errors++;
      $display("FAIL clear_contents_b: got %h %h %h %h expected 0", dut_word(0, 0), dut_word(0, 1),
               dut_word(0, 2), dut_word(0, 3));
    end
    $display("test_clear_ignored: clear-phase inputs ignored, restart done");
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 79) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_ptr  = $urandom();
      wr_mask = BS'($urandom());
      for (int i = 0; i < BS; i++) wr_block[i*W +: W] = $urandom();
      rd_en = RP'($urandom());
      for (int p = 0; p < RP; p++) begin
        if ($urandom_range(0, 1) == 1) set_rptr(p, wr_ptr + $urandom_range(0, 6) - 3);
        else set_rptr(p, $urandom());
      end
      cycle();
      bad = 0;
      checks++;
      if (init_busy !== (clear_left > 0) || rd_valid !== exp_valid) begin
        errors++;
        $display("FAIL random_ctrl[%0d]: got busy=%b valid=%b expected busy=%b valid=%b",
                 n, init_busy, rd_valid, (clear_left > 0), exp_valid);
      end
      for (int p = 0; p < RP; p++) begin
        checks++;
        if (dut_data(p) !== exp_data[p]) begin
          errors++;
          $display("FAIL random_data[%0d] port %0d: got %h expected %h", n, p, dut_data(p), exp_data[p]);
        end
        for (int i = 0; i < BS; i++) begin
          checks++;
          if (dut_word(p, i) !== exp_block[p][i]) begin
            errors++;
            bad++;
            if (bad < 4)
              $display("FAIL random_block[%0d] port %0d word %0d: got %h expected %h",
                       n, p, i, dut_word(p, i), exp_block[p][i]);
          end
        end
      end
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = '0;
    $display("test_random: 400 randomized cycles done");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_mask();
    test_same_cycle();
    test_clear_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
